// File: rtl/fm_pkg.sv
// Shared constants and helpers for the frequency-meter display driver.
package fm_pkg;

    // Active-low segment patterns, bit order g f e d c b a
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_L     = 7'h47;
    localparam logic [6:0] SEG_O     = 7'h40;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Scan position: units, tens, hundreds
    typedef enum logic [1:0] {
        DIG_U = 2'd0,
        DIG_D = 2'd1,
        DIG_H = 2'd2
    } dig_idx_t;

    // Scan order U -> D -> H -> U
    function automatic dig_idx_t next_idx(input dig_idx_t idx);
        case (idx)
            DIG_U:   return DIG_D;
            DIG_D:   return DIG_H;
            default: return DIG_U;
        endcase
    endfunction

    // Active-low one-hot digit enable for a scan position
    function automatic logic [2:0] dig_enable(input dig_idx_t idx);
        case (idx)
            DIG_U:   return 3'b110;
            DIG_D:   return 3'b101;
            DIG_H:   return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    // Decimal glyph lookup; non-decimal nibbles map to 'E'
    function automatic logic [6:0] decimal_glyph(input logic [3:0] v);
        case (v)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_E;
        endcase
    endfunction

endpackage

// File: rtl/fm_display_seg7_enc.sv
// Combinational pattern selector for one digit slot of the display.
module seg7_enc
    import fm_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    input  logic       ovf,
    input  logic       valid,
    input  dig_idx_t   idx,
    output logic [6:0] seg
);

    // Priority: no result, overflow text, bad nibble, leading-zero blank, glyph
    always_comb begin
        // NOTE: assign every output a default before any branch so no latch is inferred.
        seg = SEG_DASH;
        if (!valid) begin
            seg = SEG_DASH;
        end else if (ovf) begin
            case (idx)
                DIG_H:   seg = SEG_O;
                DIG_D:   seg = SEG_F;
                DIG_U:   seg = SEG_L;
                default: seg = SEG_DASH;
            endcase
        end else if (bcd > 4'd9) begin
            seg = SEG_E;
        end else if (blank) begin
            seg = SEG_BLANK;
        end else begin
            seg = decimal_glyph(bcd);
        end
    end

endmodule

// File: rtl/fm_display.sv
// Multiplexed 3-digit 7-segment driver: captures meter results on the
// falling edge of DONE, scans digits, and times out stale readings.
module fm_display
    import fm_pkg::*;
#(
    parameter int SCAN_DIV     = 10,
    parameter int STALE_FRAMES = 255
) (
    input  logic       CLK,
    input  logic       nCLR,
    input  logic       DONE,
    input  logic [3:0] QH,
    input  logic [3:0] QD,
    input  logic [3:0] QU,
    input  logic       Q_OVF,
    input  logic       RANGE,
    output logic [6:0] SEG,
    output logic [2:0] DIG,
    output logic       X10,
    output logic       STALE
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = $clog2(STALE_FRAMES + 1);
    localparam logic [PW-1:0] PRE_MAX   = PW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] STALE_LIM = FW'(STALE_FRAMES);

    logic          done_q;
    logic          capture;
    logic [3:0]    h_q, d_q, u_q;
    logic          ovf_q, range_q;
    logic          valid;
    logic [PW-1:0] pre_cnt;
    logic          tick;
    dig_idx_t      idx, idx_nxt;
    logic          frame_end;
    logic [FW-1:0] frame_cnt;
    logic [3:0]    sel_bcd;
    logic          sel_blank;
    logic [6:0]    seg_nxt;

    assign capture   = done_q & ~DONE;
    assign tick      = (pre_cnt == PRE_MAX);
    assign idx_nxt   = next_idx(idx);
    assign frame_end = tick && (idx == DIG_H);
    assign X10       = range_q & valid;

    // Delay DONE one cycle to find its falling edge
    always_ff @(posedge CLK or negedge nCLR) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (!nCLR) done_q <= 1'b0;
        else       done_q <= DONE;
    end

    // Latch the meter result on a DONE falling edge
    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            h_q     <= '0;
            d_q     <= '0;
            u_q     <= '0;
            ovf_q   <= 1'b0;
            range_q <= 1'b0;
        end else if (capture) begin
            h_q     <= QH;
            d_q     <= QD;
            u_q     <= QU;
            ovf_q   <= Q_OVF;
            range_q <= RANGE;
        end
    end

    // Scan prescaler, one tick per digit slot
    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR)     pre_cnt <= '0;
        else if (tick) pre_cnt <= '0;
        else           pre_cnt <= pre_cnt + PW'(1);
    end

    // Digit index advances on each tick
    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR)     idx <= DIG_U;
        else if (tick) idx <= idx_nxt;
    end

    // Validity and stale timeout; a fresh capture always wins over the timeout
    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            valid     <= 1'b0;
            STALE     <= 1'b0;
            frame_cnt <= '0;
        end else if (capture) begin
            valid     <= 1'b1;
            STALE     <= 1'b0;
            frame_cnt <= '0;
        end else if (frame_end && valid) begin
            if (frame_cnt != STALE_LIM) frame_cnt <= frame_cnt + FW'(1);
            if (frame_cnt == STALE_LIM - FW'(1)) begin
                valid <= 1'b0;
                STALE <= 1'b1;
            end
        end
    end

    // Select the nibble and blanking for the slot being loaded next
    always_comb begin
        sel_bcd   = u_q;
        sel_blank = 1'b0;
        case (idx_nxt)
            DIG_H: begin
                sel_bcd   = h_q;
                sel_blank = (h_q == 4'd0);
            end
            DIG_D: begin
                sel_bcd   = d_q;
                sel_blank = (h_q == 4'd0) && (d_q == 4'd0);
            end
            default: begin
                sel_bcd   = u_q;
                sel_blank = 1'b0;
            end
        endcase
    end

    seg7_enc u_enc (
        .bcd   (sel_bcd),
        .blank (sel_blank),
        .ovf   (ovf_q),
        .valid (valid),
        .idx   (idx_nxt),
        .seg   (seg_nxt)
    );

    // Output registers reload only on a tick and hold in between
    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            SEG <= SEG_BLANK;
            DIG <= 3'b111;
        end else if (tick) begin
            SEG <= seg_nxt;
            DIG <= dig_enable(idx_nxt);
        end
    end

endmodule
